dtm_jtag_dmi: RTL and testbench
===============================

// Module: dtm_jtag_dmi
// PURPOSE
//  RISC-V JTAG Debug Transport Module (spec 0.13 style): IEEE 1149.1 TAP with IDCODE,
//  BYPASS, DTMCS and DMI registers; converts DMI scans into a valid/ready request and
//  response handshake toward the Debug Module. Sits between the board JTAG pins and the
//  DM; successor of the IDCODE/BYPASS-only TAP, parametrised in IR width, address width
//  and idle hint.
// PARAMETERS
//  IR_W          5             instruction register width (>=5)
//  IDCODE_VALUE  32'h1BEEF001  value captured by IDCODE
//  ABITS         7             DMI address width (1..32)
//  IDLE_CYCLES   1             dtmcs.idle hint, 3 bits
//  USERCODE_VAL  32'h0         USERCODE capture value (DTM_USERCODE_EN only)
// PORTS
//  tclk           in   1       JTAG clock; state/shift on posedge, tdo on negedge
//  trst           in   1       asynchronous active-low reset
//  tms            in   1       TAP mode select
//  tdi            in   1       serial data in
//  tdo            out  1       serial data out, LSB first
//  tdo_en         out  1       1 in SHIFT_IR/SHIFT_DR/EXIT1_IR/EXIT1_DR
//  dmi_req_valid  out  1       DMI request pending
//  dmi_req_ready  in   1       DM accepts request at posedge when valid&ready
//  dmi_req_addr   out  ABITS   request address
//  dmi_req_data   out  32      write data
//  dmi_req_op     out  2       1=read, 2=write
//  dmi_rsp_valid  in   1       DM response valid
//  dmi_rsp_ready  out  1       1 while waiting for a response
//  dmi_rsp_data   in   32      read data
//  dmi_rsp_op     in   2       0=ok, 2=failed, 3=busy
// BEHAVIOUR
//  - Reset (trst=0): state=TEST_LOGIC_RESET, IR=IDCODE(5'h01 zero-extended), tdo=0,
//    dmi_req_valid=0, dmi_rsp_ready=0, addr/data/op=0, sticky stat=0, rsp data=0.
//  - TAP: standard 16-state FSM advanced on posedge by tms; entering TLR forces IR=IDCODE.
//  - IR: CAPTURE_IR loads {0..0,01}; SHIFT_IR shifts tdi in at MSB; UPDATE_IR latches.
//    Codes: IDCODE=01, DTMCS=10h, DMI=11h, BYPASS=all ones; any other code -> BYPASS.
//  - tdo updated on negedge from bit0 of selected shift register; stable across posedge.
//  - DTMCS capture: {14'b0,dmihardreset=0,dmireset=0,1'b0,idle[2:0],dmistat[1:0],
//    abits[5:0],version=4'd1}. UPDATE_DR: bit16=1 clears sticky stat; bit17=1 clears
//    sticky stat and abandons in-flight op (response discarded when it arrives).
//  - DMI shift register ABITS+34 bits {addr,data,op}. CAPTURE_DR loads
//    {last_addr, rsp_data, stat}; if an op is still outstanding, stat=3 and sticky:=3.
//  - DMI UPDATE_DR: ignored if sticky!=0. If outstanding: sticky:=3, op dropped.
//    Else op 1/2: latch addr/data/op, dmi_req_valid=1 next posedge. op 0/3: nop.
//  - Request: valid and fields held stable until valid&ready sampled; then valid=0,
//    rsp_ready=1 the same edge. Response: on rsp_valid&rsp_ready latch data; rsp_op 2
//    -> sticky:=2, 3 -> sticky:=3, 0 -> unchanged; rsp_ready=0 next edge.
//  - TLR entry does NOT affect the DMI engine or sticky stat; only trst/dmihardreset.
//  - Minimum latency: req_valid 1 tclk after UPDATE_DR; ok to capture once rsp_valid seen.
//  - Simultaneous UPDATE_DR and rsp arrival: response completes first, new op accepted.
// CONFIGURATION
//  DTM_USERCODE_EN defined: instruction 02h selects 32-bit USERCODE reg capturing
//  USERCODE_VAL. Undefined: 02h decodes as BYPASS, USERCODE_VAL unused.
// TESTING
//  1 trst pulse, TMS 0, shift 32 DR bits -> tdo LSB-first = 0x1BEEF001, tdo_en high.
//  2 IR scan shifting in 5'h1F -> tdo shows 5'b00001; 4-bit DR scan tdi=1011 -> tdo
//    delayed 1 bit, first bit 0.
//  3 IR=10h, 32-bit DR scan -> 0x00001071 (ABITS=7, IDLE_CYCLES=1).
//  4 IR=11h, DMI write addr 10h data DEADBEEF op 2, hold ready low 3 tclk -> valid and
//    fields stable; ready=1 accepts; rsp_op 0 -> next DMI capture stat=0.
//  5 DMI read, second DMI scan before rsp_valid -> captured stat=3, later scans ignored;
//    DTMCS write bit16 -> stat=0, next read op launches.
//  6 trst low while req_valid=1 -> req_valid=0, state TLR, IR=IDCODE immediately.

Source files
------------

// File: rtl/dtm_jtag_dmi.sv
// RISC-V JTAG debug transport: TAP with IDCODE/BYPASS/DTMCS/DMI, bridging DMI scans to a
// valid/ready request/response port. Optional macro DTM_USERCODE_EN adds USERCODE (IR 02h).
module dtm_jtag_dmi #(
    parameter int unsigned IR_W         = 5,
    parameter logic [31:0] IDCODE_VALUE = 32'h1BEEF001,
    parameter int unsigned ABITS        = 7,
    parameter int unsigned IDLE_CYCLES  = 1,
    parameter logic [31:0] USERCODE_VAL = 32'h0
) (
    input  logic             tclk_i,
    input  logic             trst_i,
    input  logic             tms_i,
    input  logic             tdi_i,
    output logic             tdo_o,
    output logic             tdo_en_o,
    output logic             dmi_req_valid_o,
    input  logic             dmi_req_ready_i,
    output logic [ABITS-1:0] dmi_req_addr_o,
    output logic [31:0]      dmi_req_data_o,
    output logic [1:0]       dmi_req_op_o,
    input  logic             dmi_rsp_valid_i,
    output logic             dmi_rsp_ready_o,
    input  logic [31:0]      dmi_rsp_data_i,
    input  logic [1:0]       dmi_rsp_op_i
);
    localparam int unsigned DMI_W = ABITS + 34;
    localparam logic [IR_W-1:0] IR_IDCODE = IR_W'(5'h01);
    localparam logic [IR_W-1:0] IR_DTMCS  = IR_W'(5'h10);
    localparam logic [IR_W-1:0] IR_DMI    = IR_W'(5'h11);
`ifdef DTM_USERCODE_EN
    localparam logic [IR_W-1:0] IR_USER   = IR_W'(5'h02);
`endif

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
    } tap_state_e;

    typedef enum logic [2:0] {SEL_BYPASS, SEL_IDCODE, SEL_DTMCS, SEL_DMI, SEL_USER} dr_sel_e;
    typedef enum logic [1:0] {E_IDLE, E_REQ, E_RSP, E_DROP} dmi_state_e;

    tap_state_e       tap_q, tap_d;
    dr_sel_e          dr_sel;
    dmi_state_e       e_q, e_d;
    logic [IR_W-1:0]  ir_q, ir_d, ir_sh_q, ir_sh_d;
    logic [31:0]      sh32_q, sh32_d;
    logic             byp_q, byp_d;
    logic [DMI_W-1:0] dmi_sh_q, dmi_sh_d;
    logic             tdo_q;
    logic [ABITS-1:0] addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d, rsp_data_q, rsp_data_d, rsp_data_eff;
    logic [1:0]       op_q, op_d, sticky_q, sticky_d, sticky_eff, stat_cap;
    logic             rsp_done, busy_eff, dr_bit0;
    logic [31:0]      dtmcs_cap;

    // ---------------- TAP state machine ----------------
    always_comb begin
        tap_d = tap_q;
        case (tap_q)
            TLR:     tap_d = tms_i ? TLR    : RTI;
            RTI:     tap_d = tms_i ? SEL_DR : RTI;
            SEL_DR:  tap_d = tms_i ? SEL_IR : CAP_DR;
            CAP_DR:  tap_d = tms_i ? EX1_DR : SH_DR;
            SH_DR:   tap_d = tms_i ? EX1_DR : SH_DR;
            EX1_DR:  tap_d = tms_i ? UPD_DR : PA_DR;
            PA_DR:   tap_d = tms_i ? EX2_DR : PA_DR;
            EX2_DR:  tap_d = tms_i ? UPD_DR : SH_DR;
            UPD_DR:  tap_d = tms_i ? SEL_DR : RTI;
            SEL_IR:  tap_d = tms_i ? TLR    : CAP_IR;
            CAP_IR:  tap_d = tms_i ? EX1_IR : SH_IR;
            SH_IR:   tap_d = tms_i ? EX1_IR : SH_IR;
            EX1_IR:  tap_d = tms_i ? UPD_IR : PA_IR;
            PA_IR:   tap_d = tms_i ? EX2_IR : PA_IR;
            EX2_IR:  tap_d = tms_i ? UPD_IR : SH_IR;
            UPD_IR:  tap_d = tms_i ? SEL_DR : RTI;
            default: tap_d = TLR;
        endcase
    end

    // Unknown codes fall through to BYPASS.
    always_comb begin
        dr_sel = SEL_BYPASS;
        if (ir_q == IR_IDCODE)     dr_sel = SEL_IDCODE;
        else if (ir_q == IR_DTMCS) dr_sel = SEL_DTMCS;
        else if (ir_q == IR_DMI)   dr_sel = SEL_DMI;
`ifdef DTM_USERCODE_EN
        else if (ir_q == IR_USER)  dr_sel = SEL_USER;
`endif
    end

    // ---------------- response bookkeeping ----------------
    // A response landing on the same edge as a capture/update is folded in first.
    always_comb begin
        rsp_done     = dmi_rsp_valid_i && (e_q == E_RSP || e_q == E_DROP);
        rsp_data_eff = rsp_data_q;
        sticky_eff   = sticky_q;
        if (rsp_done && e_q == E_RSP) begin
            rsp_data_eff = dmi_rsp_data_i;
            if (dmi_rsp_op_i == 2'd2)      sticky_eff = 2'd2;
            else if (dmi_rsp_op_i == 2'd3) sticky_eff = 2'd3;
        end
        busy_eff  = (e_q != E_IDLE) && !rsp_done;
        stat_cap  = busy_eff ? 2'd3 : sticky_eff;
        dtmcs_cap = {14'b0, 1'b0, 1'b0, 1'b0, 3'(IDLE_CYCLES), sticky_eff, 6'(ABITS), 4'd1};
    end

    // ---------------- IR and DR shift paths ----------------
    always_comb begin
        ir_d     = ir_q;
        ir_sh_d  = ir_sh_q;
        sh32_d   = sh32_q;
        byp_d    = byp_q;
        dmi_sh_d = dmi_sh_q;
        if (tap_q == CAP_IR) ir_sh_d = IR_IDCODE;
        if (tap_q == SH_IR)  ir_sh_d = {tdi_i, ir_sh_q[IR_W-1:1]};
        if (tap_q == UPD_IR) ir_d = ir_sh_q;
        if (tap_d == TLR)    ir_d = IR_IDCODE;
        if (tap_q == CAP_DR) begin
            byp_d = 1'b0;
            case (dr_sel)
                SEL_IDCODE: sh32_d = IDCODE_VALUE;
                SEL_DTMCS:  sh32_d = dtmcs_cap;
                SEL_USER:   sh32_d = USERCODE_VAL;
                SEL_DMI:    dmi_sh_d = {addr_q, rsp_data_eff, stat_cap};
                default:    sh32_d = sh32_q;
            endcase
        end
        if (tap_q == SH_DR) begin
            byp_d = tdi_i;
            if (dr_sel == SEL_DMI) dmi_sh_d = {tdi_i, dmi_sh_q[DMI_W-1:1]};
            else                   sh32_d   = {tdi_i, sh32_q[31:1]};
        end
    end

    // ---------------- DMI request/response engine ----------------
    always_comb begin
        e_d        = e_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        op_d       = op_q;
        rsp_data_d = rsp_data_eff;
        sticky_d   = sticky_eff;
        case (e_q)
            E_REQ:          if (dmi_req_ready_i) e_d = E_RSP;
            E_RSP, E_DROP:  if (dmi_rsp_valid_i) e_d = E_IDLE;
            default:        e_d = e_q;
        endcase
        if (tap_q == CAP_DR && dr_sel == SEL_DMI && busy_eff) sticky_d = 2'd3;
        if (tap_q == UPD_DR && dr_sel == SEL_DMI && sticky_eff == 2'd0) begin
            if (busy_eff) begin
                sticky_d = 2'd3;
            end else if (dmi_sh_q[1:0] == 2'd1 || dmi_sh_q[1:0] == 2'd2) begin
                addr_d  = dmi_sh_q[DMI_W-1:34];
                wdata_d = dmi_sh_q[33:2];
                op_d    = dmi_sh_q[1:0];
                e_d     = E_REQ;
            end
        end
        if (tap_q == UPD_DR && dr_sel == SEL_DTMCS) begin
            if (sh32_q[16] || sh32_q[17]) sticky_d = 2'd0;
            // Hard reset: an accepted op still owes a response, which gets swallowed.
            if (sh32_q[17]) begin
                rsp_data_d = rsp_data_q;
                case (e_q)
                    E_REQ:   e_d = dmi_req_ready_i ? E_DROP : E_IDLE;
                    E_RSP:   e_d = dmi_rsp_valid_i ? E_IDLE : E_DROP;
                    default: e_d = e_d;
                endcase
            end
        end
    end

    always_ff @(posedge tclk_i or negedge trst_i) begin
        if (!trst_i) begin
            tap_q      <= TLR;
            ir_q       <= IR_IDCODE;
            ir_sh_q    <= '0;
            sh32_q     <= '0;
            byp_q      <= 1'b0;
            dmi_sh_q   <= '0;
            e_q        <= E_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            op_q       <= '0;
            rsp_data_q <= '0;
            sticky_q   <= '0;
        end else begin
            tap_q      <= tap_d;
            ir_q       <= ir_d;
            ir_sh_q    <= ir_sh_d;
            sh32_q     <= sh32_d;
            byp_q      <= byp_d;
            dmi_sh_q   <= dmi_sh_d;
            e_q        <= e_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            op_q       <= op_d;
            rsp_data_q <= rsp_data_d;
            sticky_q   <= sticky_d;
        end
    end

    // ---------------- TDO, launched on the falling edge ----------------
    always_comb begin
        case (dr_sel)
            SEL_IDCODE, SEL_DTMCS, SEL_USER: dr_bit0 = sh32_q[0];
            SEL_DMI:                         dr_bit0 = dmi_sh_q[0];
            default:                         dr_bit0 = byp_q;
        endcase
    end

    always_ff @(negedge tclk_i or negedge trst_i) begin
        if (!trst_i)              tdo_q <= 1'b0;
        else if (tap_q == SH_IR)  tdo_q <= ir_sh_q[0];
        else if (tap_q == SH_DR)  tdo_q <= dr_bit0;
    end

    assign tdo_o           = tdo_q;
    assign tdo_en_o        = (tap_q == SH_IR) || (tap_q == SH_DR) ||
                             (tap_q == EX1_IR) || (tap_q == EX1_DR);
    assign dmi_req_valid_o = (e_q == E_REQ);
    assign dmi_rsp_ready_o = (e_q == E_RSP) || (e_q == E_DROP);
    assign dmi_req_addr_o  = addr_q;
    assign dmi_req_data_o  = wdata_q;
    assign dmi_req_op_o    = op_q;
endmodule

// File: tb/tb_dtm_jtag_dmi.sv
// Directed bench for dtm_jtag_dmi: drives TAP scans and a hand-played DM, compares against
// hand-computed scan results and handshake levels.
module tb_dtm_jtag_dmi;
    localparam int ABITS = 7;

    logic             tclk = 1'b0, trst = 1'b0, tms = 1'b0, tdi = 1'b0;
    logic             tdo, tdo_en;
    logic             req_valid, req_ready = 1'b0, rsp_ready, rsp_valid = 1'b0;
    logic [ABITS-1:0] req_addr;
    logic [31:0]      req_data, rsp_data = 32'h0;
    logic [1:0]       req_op, rsp_op = 2'd0;

    int checks = 0;
    int errors = 0;

    dtm_jtag_dmi dut (
        .tclk_i(tclk), .trst_i(trst), .tms_i(tms), .tdi_i(tdi),
        .tdo_o(tdo), .tdo_en_o(tdo_en),
        .dmi_req_valid_o(req_valid), .dmi_req_ready_i(req_ready),
        .dmi_req_addr_o(req_addr), .dmi_req_data_o(req_data), .dmi_req_op_o(req_op),
        .dmi_rsp_valid_i(rsp_valid), .dmi_rsp_ready_o(rsp_ready),
        .dmi_rsp_data_i(rsp_data), .dmi_rsp_op_i(rsp_op)
    );

    always #10 tclk = ~tclk;

    // One TCK: inputs set after posedge, TDO sampled mid-low phase, returns 1 after posedge.
    task automatic step(input logic m, input logic d, output logic o, output logic en);
        tms = m;
        tdi = d;
        @(negedge tclk); #2;
        o  = tdo;
        en = tdo_en;
        @(posedge tclk); #1;
    endtask

    task automatic idle(input int n);
        logic o, e;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, o, e);
    endtask

    // From RTI, full DR scan back to RTI; the update takes effect on the final edge.
    task automatic scan_dr(input int n, input logic [63:0] din, output logic [63:0] dout,
                           output logic en_all);
        logic o, e;
        dout = '0;
        en_all = 1'b1;
        step(1'b1, 1'b0, o, e);
        step(1'b0, 1'b0, o, e);
        step(1'b0, 1'b0, o, e);
        for (int i = 0; i < n; i++) begin
            step(i == n - 1, din[i], o, e);
            dout[i] = o;
            en_all  = en_all & e;
        end
        step(1'b1, 1'b0, o, e);
        step(1'b0, 1'b0, o, e);
        $display("DR scan n=%0d din=%h dout=%h", n, din, dout);
    endtask

    task automatic scan_ir(input logic [4:0] din, output logic [4:0] dout);
        logic o, e;
        dout = '0;
        step(1'b1, 1'b0, o, e);
        step(1'b1, 1'b0, o, e);
        step(1'b0, 1'b0, o, e);
        step(1'b0, 1'b0, o, e);
        for (int i = 0; i < 5; i++) begin
            step(i == 4, din[i], o, e);
            dout[i] = o;
        end
        step(1'b1, 1'b0, o, e);
        step(1'b0, 1'b0, o, e);
        $display("IR scan din=%h dout=%h", din, dout);
    endtask

    task automatic test_reset;
        repeat (2) @(posedge tclk);
        #1;
        checks++; if (tdo !== 1'b0)       begin errors++; $display("FAIL reset_tdo got %h exp 0", tdo); end
        checks++; if (tdo_en !== 1'b0)    begin errors++; $display("FAIL reset_tdo_en got %h exp 0", tdo_en); end
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %h exp 0", req_valid); end
        checks++; if (rsp_ready !== 1'b0) begin errors++; $display("FAIL reset_rsp_ready got %h exp 0", rsp_ready); end
        checks++; if (req_addr !== 7'h0)  begin errors++; $display("FAIL reset_addr got %h exp 0", req_addr); end
        checks++; if (req_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", req_data); end
        checks++; if (req_op !== 2'd0)    begin errors++; $display("FAIL reset_op got %h exp 0", req_op); end
        trst = 1'b1;
        $display("reset released");
    endtask

    task automatic test_idcode;
        logic [63:0] d;
        logic en;
        idle(1);
        scan_dr(32, 64'h0, d, en);
        checks++; if (d !== 64'h1BEEF001) begin errors++; $display("FAIL idcode got %h exp 1beef001", d); end
        checks++; if (en !== 1'b1)        begin errors++; $display("FAIL idcode_tdo_en got %h exp 1", en); end
    endtask

    task automatic test_bypass;
        logic [4:0]  ir;
        logic [63:0] d;
        logic en;
        scan_ir(5'h1F, ir);
        checks++; if (ir !== 5'b00001) begin errors++; $display("FAIL ir_capture got %b exp 00001", ir); end
        scan_dr(4, 64'b1011, d, en);
        checks++; if (d !== 64'b0110)  begin errors++; $display("FAIL bypass_1f got %b exp 0110", d[3:0]); end
        scan_ir(5'h02, ir);
        scan_dr(4, 64'b1011, d, en);
        checks++; if (d !== 64'b0110)  begin errors++; $display("FAIL bypass_02 got %b exp 0110", d[3:0]); end
        scan_ir(5'h05, ir);
        scan_dr(4, 64'b0101, d, en);
        checks++; if (d !== 64'b1010)  begin errors++; $display("FAIL bypass_05 got %b exp 1010", d[3:0]); end
    endtask

    task automatic test_dtmcs;
        logic [4:0]  ir;
        logic [63:0] d;
        logic en;
        scan_ir(5'h10, ir);
        checks++; if (ir !== 5'b00001)    begin errors++; $display("FAIL dtmcs_ir_capture got %b exp 00001", ir); end
        scan_dr(32, 64'h0, d, en);
        checks++; if (d !== 64'h00001071) begin errors++; $display("FAIL dtmcs got %h exp 00001071", d); end
    endtask

    task automatic test_dmi_write;
        logic [4:0]  ir;
        logic [63:0] d;
        logic en;
        scan_ir(5'h11, ir);
        scan_dr(41, 64'({7'h10, 32'hDEADBEEF, 2'd2}), d, en);
        checks++; if (d !== 64'h0) begin errors++; $display("FAIL dmi_first_capture got %h exp 0", d); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (req_valid !== 1'b1)        begin errors++; $display("FAIL wr_valid_hold%0d got %h exp 1", i, req_valid); end
            checks++; if (req_addr !== 7'h10)        begin errors++; $display("FAIL wr_addr_hold%0d got %h exp 10", i, req_addr); end
            checks++; if (req_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_data_hold%0d got %h exp deadbeef", i, req_data); end
            checks++; if (req_op !== 2'd2)           begin errors++; $display("FAIL wr_op_hold%0d got %h exp 2", i, req_op); end
            if (i < 3) idle(1);
        end
        req_ready = 1'b1;
        idle(1);
        req_ready = 1'b0;
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL wr_accept_valid got %h exp 0", req_valid); end
        checks++; if (rsp_ready !== 1'b1) begin errors++; $display("FAIL wr_rsp_ready got %h exp 1", rsp_ready); end
        rsp_valid = 1'b1; rsp_op = 2'd0; rsp_data = 32'h12345678;
        idle(1);
        rsp_valid = 1'b0;
        checks++; if (rsp_ready !== 1'b0) begin errors++; $display("FAIL wr_rsp_done got %h exp 0", rsp_ready); end
        scan_dr(41, 64'h0, d, en);
        checks++; if (d !== 64'({7'h10, 32'h12345678, 2'd0})) begin errors++; $display("FAIL wr_rsp_capture got %h exp %h", d, 64'({7'h10, 32'h12345678, 2'd0})); end
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL nop_no_req got %h exp 0", req_valid); end
    endtask

    task automatic test_dmi_busy;
        logic [4:0]  ir;
        logic [63:0] d;
        logic en;
        scan_dr(41, 64'({7'h05, 32'h0, 2'd1}), d, en);
        checks++; if (req_valid !== 1'b1 || req_op !== 2'd1 || req_addr !== 7'h05) begin errors++; $display("FAIL rd_launch got v%h op%h a%h exp v1 op1 a05", req_valid, req_op, req_addr); end
        req_ready = 1'b1;
        idle(1);
        req_ready = 1'b0;
        scan_dr(41, 64'({7'h06, 32'h0, 2'd1}), d, en);
        checks++; if (d !== 64'({7'h05, 32'h12345678, 2'd3})) begin errors++; $display("FAIL busy_capture got %h exp %h", d, 64'({7'h05, 32'h12345678, 2'd3})); end
        rsp_valid = 1'b1; rsp_op = 2'd0; rsp_data = 32'hCAFEF00D;
        idle(1);
        rsp_valid = 1'b0;
        scan_dr(41, 64'({7'h07, 32'h0, 2'd1}), d, en);
        checks++; if (d !== 64'({7'h05, 32'hCAFEF00D, 2'd3})) begin errors++; $display("FAIL sticky_capture got %h exp %h", d, 64'({7'h05, 32'hCAFEF00D, 2'd3})); end
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL sticky_ignored got %h exp 0", req_valid); end
        scan_ir(5'h10, ir);
        scan_dr(32, 64'h00010000, d, en);
        checks++; if (d !== 64'h00001C71) begin errors++; $display("FAIL dtmcs_stat3 got %h exp 00001c71", d); end
        scan_ir(5'h11, ir);
        scan_dr(41, 64'({7'h07, 32'h0, 2'd1}), d, en);
        checks++; if (d !== 64'({7'h05, 32'hCAFEF00D, 2'd0})) begin errors++; $display("FAIL cleared_capture got %h exp %h", d, 64'({7'h05, 32'hCAFEF00D, 2'd0})); end
        checks++; if (req_valid !== 1'b1 || req_addr !== 7'h07) begin errors++; $display("FAIL relaunch got v%h a%h exp v1 a07", req_valid, req_addr); end
        req_ready = 1'b1;
        idle(1);
        req_ready = 1'b0;
        rsp_valid = 1'b1; rsp_op = 2'd2; rsp_data = 32'h0;
        idle(1);
        rsp_valid = 1'b0;
        scan_ir(5'h10, ir);
        scan_dr(32, 64'h00020000, d, en);
        checks++; if (d !== 64'h00001871) begin errors++; $display("FAIL dtmcs_stat2 got %h exp 00001871", d); end
        scan_dr(32, 64'h0, d, en);
        checks++; if (d !== 64'h00001071) begin errors++; $display("FAIL hardreset_clear got %h exp 00001071", d); end
    endtask

    task automatic test_tlr;
        logic [63:0] d;
        logic o, e;
        logic en;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, o, e);
        idle(1);
        scan_dr(32, 64'h0, d, en);
        checks++; if (d !== 64'h1BEEF001) begin errors++; $display("FAIL tlr_idcode got %h exp 1beef001", d); end
    endtask

    task automatic test_reset_midop;
        logic [4:0]  ir;
        logic [63:0] d;
        logic en;
        scan_ir(5'h11, ir);
        scan_dr(41, 64'({7'h01, 32'h1, 2'd2}), d, en);
        checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL midop_valid got %h exp 1", req_valid); end
        #3 trst = 1'b0;
        #1;
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL midop_reset_valid got %h exp 0", req_valid); end
        checks++; if (req_addr !== 7'h0)  begin errors++; $display("FAIL midop_reset_addr got %h exp 0", req_addr); end
        checks++; if (tdo_en !== 1'b0)    begin errors++; $display("FAIL midop_reset_tdo_en got %h exp 0", tdo_en); end
        @(posedge tclk); #1;
        trst = 1'b1;
        idle(1);
        scan_dr(32, 64'h0, d, en);
        checks++; if (d !== 64'h1BEEF001) begin errors++; $display("FAIL midop_idcode got %h exp 1beef001", d); end
    endtask

    initial begin
        test_reset();
        test_idcode();
        test_bypass();
        test_dtmcs();
        test_dmi_write();
        test_dmi_busy();
        test_tlr();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout got running exp finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
